cordic_engine: RTL and testbench



---
 rtl/cordic_pkg.sv | 44 ++++
 rtl/cordic_engine_if.sv | 32 +++
 rtl/cordic_microrot.sv | 58 +++++
 rtl/cordic_engine.sv | 139 +++++++++++++
 tb/tb_cordic_engine.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared types and elaboration-time constant helpers for the iterative CORDIC engine.
// The gain and arctangent tables are computed from real math while the design elaborates.
package cordic_pkg;

  typedef enum logic {
    ROTATE = 1'b0,
    VECTOR = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam real PI = 3.14159265358979323846;

  // Product of 1/sqrt(1+2^-2k) for k<iters, scaled so that 1.0 = 2^(width-2+guard).
  function automatic int cordic_gain_k(int width, int iters, int guard);
    real p;
    p = 1.0;
    for (int k = 0; k < iters; k++) begin
      p = p / $sqrt(1.0 + 1.0 / (4.0 ** k));
    end
    return $rtoi(p * (2.0 ** (width - 2 + guard)) + 0.5);
  endfunction

  // atan(2^-i) as a binary angle where pi = 2^(width-1+guard).
  function automatic int cordic_atan(int i, int width, int guard);
    return $rtoi($atan(1.0 / (2.0 ** i)) / PI * (2.0 ** (width - 1 + guard)) + 0.5);
  endfunction

  // Clamp a signed value into the two's-complement range of a width-bit word.
  function automatic longint saturate(longint v, int width);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (width - 1)) - 1;
    lo = -(longint'(1) <<< (width - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cordic_engine_if.sv
// Valid/ready request and result channels of the CORDIC engine.
// The master side issues operands and accepts results; the engine is the slave.
interface cordic_engine_if
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16
);

  logic                    in_valid;
  logic                    in_ready;
  mode_e                   in_mode;
  logic signed [WIDTH-1:0] in_x;
  logic signed [WIDTH-1:0] in_y;
  logic signed [WIDTH-1:0] in_z;

  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_x;
  logic signed [WIDTH-1:0] out_y;
  logic signed [WIDTH-1:0] out_z;

  modport master (
    output in_valid, in_mode, in_x, in_y, in_z, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z
  );

  modport slave (
    input  in_valid, in_mode, in_x, in_y, in_z, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z
  );

endinterface

// File: rtl/cordic_microrot.sv
// One combinational CORDIC micro-rotation: direction decision, shift-add on x/y and
// arctangent update on z, selected by the iteration index.
module cordic_microrot
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITERS = 14,
  parameter int GUARD = 2,
  parameter int XW    = WIDTH + 1 + GUARD,
  parameter int ZW    = WIDTH + GUARD,
  parameter int IW    = 4
) (
  input  logic signed [XW-1:0] x,
  input  logic signed [XW-1:0] y,
  input  logic        [ZW-1:0] z,
  input  logic        [IW-1:0] i,
  input  mode_e                mode,
  output logic signed [XW-1:0] x_next,
  output logic signed [XW-1:0] y_next,
  output logic        [ZW-1:0] z_next
);

  localparam int DEPTH = 1 << IW;

  // Table padded to the full index range so every value of i selects a defined entry.
  logic [ZW-1:0] atan_tab [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_atan
    if (g < ITERS) begin : g_used
      assign atan_tab[g] = ZW'(cordic_atan(g, WIDTH, GUARD));
    end else begin : g_pad
      assign atan_tab[g] = '0;
    end
  end

  logic                d_pos;
  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;
  logic        [ZW-1:0] atan_i;

  assign d_pos  = (mode == ROTATE) ? ~z[ZW-1] : y[XW-1];
  assign x_sh   = x >>> i;
  assign y_sh   = y >>> i;
  assign atan_i = atan_tab[i];

  always_comb begin
    if (d_pos) begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - atan_i;
    end else begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + atan_i;
    end
  end

endmodule

// File: rtl/cordic_engine.sv
// Iterative CORDIC engine: quadrant fold at accept, one micro-rotation per clock,
// rounded/saturated result held under a valid/ready handshake until taken.
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITERS = 14,
  parameter int GUARD = 2
) (
  input  logic           clk,
  input  logic           reset,
  cordic_engine_if.slave bus
);

  localparam int XW = WIDTH + 1 + GUARD;
  localparam int ZW = WIDTH + GUARD;
  localparam int IW = (ITERS > 1) ? $clog2(ITERS) : 1;

  localparam logic signed [XW-1:0] K0   = XW'(cordic_gain_k(WIDTH, ITERS, GUARD));
  localparam logic        [IW-1:0] LAST = IW'(ITERS - 1);
  localparam logic        [ZW-1:0] Z_PI = {1'b1, {(ZW-1){1'b0}}};
  localparam longint               HALF = (longint'(1) <<< GUARD) >>> 1;

  state_e               state;
  mode_e                mode;
  logic signed [XW-1:0] x, y;
  logic        [ZW-1:0] z;
  logic        [IW-1:0] iter;

  logic signed [XW-1:0] x_n, y_n;
  logic        [ZW-1:0] z_n;

  logic signed [WIDTH-1:0] out_x, out_y, out_z;
  logic                    out_valid;

  cordic_microrot #(
    .WIDTH(WIDTH), .ITERS(ITERS), .GUARD(GUARD), .XW(XW), .ZW(ZW), .IW(IW)
  ) u_step (
    .x(x), .y(y), .z(z), .i(iter), .mode(mode),
    .x_next(x_n), .y_next(y_n), .z_next(z_n)
  );

  // Quadrant fold of the incoming operands, ready to be captured on accept.
  logic signed [XW-1:0] in_x_ext, in_y_ext;
  logic                 far_half;
  logic    [WIDTH-1:0]  z_fold;
  logic signed [XW-1:0] x0, y0;
  logic        [ZW-1:0] z0;

  assign in_x_ext = XW'(bus.in_x) <<< GUARD;
  assign in_y_ext = XW'(bus.in_y) <<< GUARD;
  assign far_half = bus.in_z[WIDTH-1] ^ bus.in_z[WIDTH-2];
  assign z_fold   = {bus.in_z[WIDTH-1] ^ far_half, bus.in_z[WIDTH-2:0]};

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    x0 = '0;
    y0 = '0;
    z0 = '0;
    if (bus.in_mode == ROTATE) begin
      x0 = far_half ? -K0 : K0;
      z0 = ZW'(z_fold) << GUARD;
    end else if (bus.in_x[WIDTH-1]) begin
      x0 = -in_x_ext;
      y0 = -in_y_ext;
      z0 = Z_PI;
    end else begin
      x0 = in_x_ext;
      y0 = in_y_ext;
    end
  end

  // Round half-up while dropping the guard bits; x/y then clamp, z simply wraps.
  longint        x_rnd, y_rnd;
  logic [ZW-1:0] z_rnd;

  always_comb begin
    x_rnd = (longint'(x_n) + HALF) >>> GUARD;
    y_rnd = (longint'(y_n) + HALF) >>> GUARD;
    z_rnd = z_n + ZW'(HALF);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mode      <= ROTATE;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      iter      <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mode  <= bus.in_mode;
            x     <= x0;
            y     <= y0;
            z     <= z0;
            iter  <= '0;
            state <= ROT;
          end
        end
        ROT: begin
          x <= x_n;
          y <= y_n;
          z <= z_n;
          if (iter == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_x     <= WIDTH'(saturate(x_rnd, WIDTH));
            out_y     <= WIDTH'(saturate(y_rnd, WIDTH));
            out_z     <= z_rnd[ZW-1 -: WIDTH];
          end else begin
            iter <= iter + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !reset;
  assign bus.out_valid = out_valid;
  assign bus.out_x     = out_x;
  assign bus.out_y     = out_y;
  assign bus.out_z     = out_z;

endmodule

// File: tb/tb_cordic_engine.sv
// Directed-vector bench for cordic_engine: table of rotation/vectoring cases with
// hand-computed results, plus handshake, back-to-back and mid-transaction reset sequences.
module tb_cordic_engine;
  import cordic_pkg::*;

  localparam int WIDTH = 16;
  localparam int ITERS = 14;
  localparam int GUARD = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_engine_if #(.WIDTH(WIDTH)) bus ();

  cordic_engine #(.WIDTH(WIDTH), .ITERS(ITERS), .GUARD(GUARD)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    string name;
    mode_e mode;
    int    x, y, z;
    int    ex, ey, ez;
    int    tx, ty, tz;   // tolerance; negative skips that output
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol,
                            input bit wrap);
    int diff;
    logic signed [WIDTH-1:0] d16;
    diff = act - exp;
    if (wrap) begin
      d16  = WIDTH'(diff);
      diff = int'(d16);
    end
    if (diff < 0) diff = -diff;
    checks++;
    if (diff > tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // One transaction: optional in_valid pokes during ROT and optional DONE hold cycles.
  task automatic do_txn(input vec_t v, input int hold, input bit poke,
                        output int ox, output int oy, output int oz, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_eq({v.name, "_in_ready"}, int'(bus.in_ready), 1);
    bus.in_mode  = v.mode;
    bus.in_x     = WIDTH'(v.x);
    bus.in_y     = WIDTH'(v.y);
    bus.in_z     = WIDTH'(v.z);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (poke && (lat == 3 || lat == 7)) begin
        check_eq("rot_in_ready_low", int'(bus.in_ready), 0);
        bus.in_mode  = VECTOR;
        bus.in_x     = WIDTH'(-8192);
        bus.in_z     = 16'sd0;
        bus.in_valid = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    ox = int'(bus.out_x);
    oy = int'(bus.out_y);
    oz = int'(bus.out_z);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("hold_out_valid", int'(bus.out_valid), 1);
      check_eq("hold_in_ready", int'(bus.in_ready), 0);
      check_near("hold_out_x", int'(bus.out_x), v.ex, v.tx, 1'b0);
      check_near("hold_out_z", int'(bus.out_z), v.ez, v.tz, 1'b1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq({v.name, "_released"}, int'(bus.out_valid), 0);
  endtask

  vec_t vecs[10];
  vec_t v;
  int   ox, oy, oz, lat;
  int   acc[3];
  int   n_acc, n_res, n_spur;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"rot_z0",     ROTATE,      0,      0,      0,  16384,      0,      0, 4, 4, 4};
    vecs[1] = '{"rot_pi6",    ROTATE,      0,      0,   5461,  14189,   8192,      0, 4, 4, 4};
    vecs[2] = '{"rot_3pi4",   ROTATE,      0,      0,  24576, -11585,  11585,      0, 4, 4, 4};
    vecs[3] = '{"rot_mpi",    ROTATE,      0,      0, -32768, -16384,      0,      0, 4, 4, 4};
    vecs[4] = '{"rot_mpi4",   ROTATE,      0,      0,  -8192,  11585, -11585,      0, 4, 4, 4};
    vecs[5] = '{"vec_45",     VECTOR,   8192,   8192,      0,  19079,      0,   8192, 6, -1, 4};
    vecs[6] = '{"vec_negx",   VECTOR, -16384,      0,      0,  26982,      0, -32768, 6, -1, 4};
    vecs[7] = '{"vec_sat",    VECTOR,  16384,  16384,      0,  32767,      0,   8192, 0, -1, 4};
    vecs[8] = '{"vec_mpi2",   VECTOR,      0, -16384,      0,  26982,      0, -16384, 6, -1, 4};
    vecs[9] = '{"vec_3pi4",   VECTOR,  -8192,   8192,      0,  19079,      0,  24576, 6, -1, 4};

    bus.in_valid  = 1'b0;
    bus.in_mode   = ROTATE;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_z      = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_out_valid", int'(bus.out_valid), 0);
    check_eq("reset_in_ready", int'(bus.in_ready), 0);
    check_eq("reset_out_x", int'(bus.out_x), 0);
    check_eq("reset_out_z", int'(bus.out_z), 0);
    reset = 1'b0;
    #1;
    check_eq("post_reset_in_ready", int'(bus.in_ready), 1);

    // Directed vectors
    for (int k = 0; k < 10; k++) begin
      do_txn(vecs[k], 0, 1'b0, ox, oy, oz, lat);
      check_eq({vecs[k].name, "_latency"}, lat, ITERS);
      check_near({vecs[k].name, "_x"}, ox, vecs[k].ex, vecs[k].tx, 1'b0);
      if (vecs[k].ty >= 0) check_near({vecs[k].name, "_y"}, oy, vecs[k].ey, vecs[k].ty, 1'b0);
      check_near({vecs[k].name, "_z"}, oz, vecs[k].ez, vecs[k].tz, 1'b1);
    end

    // DONE hold for 5 cycles with in_valid pokes during ROT
    v = vecs[1];
    do_txn(v, 5, 1'b1, ox, oy, oz, lat);
    check_eq("poke_latency", lat, ITERS);
    check_near("poke_x", ox, v.ex, v.tx, 1'b0);
    check_near("poke_y", oy, v.ey, v.ty, 1'b0);
    n_spur = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) n_spur++;
    end
    check_eq("poke_no_extra_result", n_spur, 0);

    // Back-to-back: in_valid and out_ready held high
    @(negedge clk);
    bus.in_mode   = ROTATE;
    bus.in_z      = 16'sd0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    n_acc = 0;
    n_res = 0;
    for (int c = 0; c < 80 && n_acc < 3; c++) begin
      if (bus.in_ready) begin
        acc[n_acc] = cyc;
        n_acc++;
      end
      if (bus.out_valid) begin
        n_res++;
        check_near("b2b_x", int'(bus.out_x), 16384, 4, 1'b0);
      end
      if (n_acc < 3) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) n_res++;
    end
    bus.out_ready = 1'b0;
    check_eq("b2b_accepts", n_acc, 3);
    check_eq("b2b_period_1", acc[1] - acc[0], ITERS + 2);
    check_eq("b2b_period_2", acc[2] - acc[1], ITERS + 2);
    check_eq("b2b_results", n_res, 3);

    // Reset during ROT iteration 5 aborts the transaction and clears the outputs
    @(negedge clk);
    bus.in_mode  = ROTATE;
    bus.in_z     = 16'sd8192;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_out_valid", int'(bus.out_valid), 0);
    check_eq("abort_out_x", int'(bus.out_x), 0);
    check_eq("abort_out_y", int'(bus.out_y), 0);
    check_eq("abort_out_z", int'(bus.out_z), 0);
    check_eq("abort_in_ready", int'(bus.in_ready), 0);
    reset = 1'b0;
    #1;
    check_eq("abort_release_in_ready", int'(bus.in_ready), 1);
    n_spur = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) n_spur++;
    end
    check_eq("abort_no_partial", n_spur, 0);

    v = '{"rot_pi4", ROTATE, 0, 0, 8192, 11585, 11585, 0, 4, 4, 4};
    do_txn(v, 0, 1'b0, ox, oy, oz, lat);
    check_eq("after_abort_latency", lat, ITERS);
    check_near("after_abort_x", ox, v.ex, v.tx, 1'b0);
    check_near("after_abort_y", oy, v.ey, v.ty, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
